// File: rtl/rstatus_controller_pkg.sv
// Shared definitions for the rstatus controller: FSM encoding, default target register, overflow codes.
package rstatus_controller_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } rs_state_t;

  localparam int unsigned RSTATUS_REG_DEF = 30;

  localparam logic [31:0] OVF_ADD  = 32'd1;
  localparam logic [31:0] OVF_ADDI = 32'd2;
  localparam logic [31:0] OVF_SUB  = 32'd3;

endpackage

// File: rtl/rstatus_controller_sat_counter.sv
// Saturating up-counter: one step per enabled edge, 0 latency, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rstatus_controller.sv
// Captures overflow/setx rstatus values and writes them to the regfile one cycle later.
// Write stalls while normal writeback owns the port; a newer capture supersedes an unwritten value.
module rstatus_controller
  import rstatus_controller_pkg::*;
#(
  parameter int unsigned RSTATUS_REG = RSTATUS_REG_DEF,
  parameter int unsigned COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ovf_valid,
  input  logic [31:0]        ovf_code,
  input  logic               setx_valid,
  input  logic [26:0]        setx_target,
  input  logic               wb_busy,
  input  logic               bex_query,
  output logic               rs_we,
  output logic [4:0]         rs_waddr,
  output logic [31:0]        rs_wdata,
  output logic [31:0]        rstatus,
  output logic               bex_taken,
  output logic               pending,
  output logic [COUNT_W-1:0] ovf_count
);

  rs_state_t   state, state_nxt;
  logic        capture;
  logic [31:0] capture_val;

  // Overflow wins when both sources fire in the same cycle.
  assign capture     = ovf_valid | setx_valid;
  assign capture_val = ovf_valid ? ovf_code : {5'b0, setx_target};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rstatus <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rstatus <= capture_val;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rs_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (capture) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        rs_we = !wb_busy;
        if (rs_we && !capture) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pending   = (state == ST_PEND);
  assign rs_waddr  = 5'(RSTATUS_REG);
  assign rs_wdata  = rstatus;
  // Decision uses the registered value only; same-cycle captures are not forwarded.
  assign bex_taken = bex_query && (rstatus != '0);

  sat_counter #(
    .W (COUNT_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ovf_valid),
    .cnt   (ovf_count)
  );

endmodule
